// File: rtl/tx_msg_formatter.sv
`default_nettype none
//==============================================================================
// Module   : tx_msg_formatter
// Function : Formats an ASCII status line for a UART transmitter:
//            "current state:<mode label>  rate:<digits><terminator>".
//            The rate is converted to BCD by a serial double-dabble.
//            Optional macro TX_MSG_CRLF_EN selects a CR+LF terminator
//            (default: LF only).
// Revision : 1.0 - initial release
//==============================================================================
module tx_msg_formatter #(
    parameter int RATE_W      = 8,
    parameter int RATE_DIGITS = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iTX_START_CONTROL,
    input  logic              iTX_INITIAL,
    input  logic              iTX_NORMAL,
    input  logic [RATE_W-1:0] iRATE,
    input  logic              iFINISH,
    input  logic              iReady,
    output logic [7:0]        oTX_DATA,
    output logic              oValid,
    output logic              oBusy,
    output logic              oMsgDone
);

`ifdef TX_MSG_CRLF_EN
    localparam int c_TERM_LEN = 2;
`else
    localparam int c_TERM_LEN = 1;
`endif
    localparam int c_MSG_LEN = 33 + RATE_DIGITS + c_TERM_LEN;
    localparam int c_IDX_W   = $clog2(c_MSG_LEN + 1);
    localparam int c_BCD_W   = 4 * RATE_DIGITS;
    localparam int c_CNT_W   = $clog2(RATE_W + 1);
    localparam int c_CMP_W   = (RATE_W > 17) ? RATE_W : 17;
    localparam int c_MAX_RATE = (10 ** RATE_DIGITS) - 1;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_MSG_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_CONV_END = c_CNT_W'(RATE_W - 1);

    localparam logic [1:0] c_MODE_NORMAL  = 2'd0;
    localparam logic [1:0] c_MODE_INITIAL = 2'd1;
    localparam logic [1:0] c_MODE_CONTROL = 2'd2;

    // Constant text fragments (message ROM)
    localparam logic [111:0] c_HEAD       = "current state:";
    localparam logic [55:0]  c_MID        = "  rate:";
    localparam logic [95:0]  c_LBL_CTRL   = "rate control";
    localparam logic [95:0]  c_LBL_INIT   = "initial     ";
    localparam logic [95:0]  c_LBL_NORMAL = "normal      ";

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t              r_state;
    logic [1:0]          r_mode;
    logic [RATE_W-1:0]   r_rate;
    logic [RATE_W-1:0]   r_bin;
    logic [c_BCD_W-1:0]  r_bcd;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [7:0]          r_data;
    logic                r_valid;
    logic                r_busy;
    logic                r_done;

    logic                w_anyMode;
    logic [1:0]          w_reqMode;
    logic                w_sat;
    logic [c_BCD_W-1:0]  w_adj;
    logic [c_IDX_W-1:0]  w_nextIdx;
    logic [7:0]          w_nextByte;

    // Byte of the message at a given index
    function automatic logic [7:0] msgByte(
        input logic [c_IDX_W-1:0] idx,
        input logic [1:0]         mode,
        input logic [c_BCD_W-1:0] bcd,
        input logic               sat
    );
        int          i;
        int          dig;
        logic [95:0] lbl;
        logic [7:0]  b;
        i   = int'(idx);
        dig = 0;
        b   = 8'hFF;
        case (mode)
            c_MODE_CONTROL: lbl = c_LBL_CTRL;
            c_MODE_INITIAL: lbl = c_LBL_INIT;
            default:        lbl = c_LBL_NORMAL;
        endcase
        if (i < 14) begin
            b = c_HEAD[8*(13-i) +: 8];
        end else if (i < 26) begin
            b = lbl[8*(25-i) +: 8];
        end else if (i < 33) begin
            b = c_MID[8*(32-i) +: 8];
        end else if (i < 33 + RATE_DIGITS) begin
            dig = RATE_DIGITS - 1 - (i - 33);
            b   = sat ? 8'h39 : {4'h3, bcd[4*dig +: 4]};
`ifdef TX_MSG_CRLF_EN
        end else if (i == 33 + RATE_DIGITS) begin
            b = 8'h0D;
        end else begin
            b = 8'h0A;
        end
`else
        end else begin
            b = 8'h0A;
        end
`endif
        return b;
    endfunction

    // Mode request priority: rate control > initial > normal
    assign w_anyMode = iTX_START_CONTROL | iTX_INITIAL | iTX_NORMAL;
    assign w_reqMode = iTX_START_CONTROL ? c_MODE_CONTROL :
                       iTX_INITIAL       ? c_MODE_INITIAL : c_MODE_NORMAL;

    // Rates that do not fit in the digit field display as all nines
    assign w_sat = ({{(c_CMP_W-RATE_W){1'b0}}, r_rate} > c_CMP_W'(c_MAX_RATE));

    // Double-dabble add-3 correction of every BCD digit
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < RATE_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // Byte to present after the current one is accepted (byte 0 when entering SEND)
    always_comb begin
        w_nextIdx  = (r_state == ST_SEND) ? (r_idx + 1'b1) : '0;
        w_nextByte = msgByte(w_nextIdx, r_mode, r_bcd, w_sat);
    end

    // Message sequencer: latch request, convert rate, stream bytes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_mode  <= c_MODE_NORMAL;
            r_rate  <= '0;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= 8'hFF;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (iFINISH) begin
                r_state <= ST_IDLE;
                r_idx   <= '0;
                r_data  <= 8'hFF;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_data  <= 8'hFF;
                        r_valid <= 1'b0;
                        if (w_anyMode) begin
                            r_mode  <= w_reqMode;
                            r_rate  <= iRATE;
                            r_bin   <= iRATE;
                            r_bcd   <= '0;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_CONV;
                        end
                    end
                    ST_CONV: begin
                        r_bcd <= {w_adj[c_BCD_W-2:0], r_bin[RATE_W-1]};
                        r_bin <= r_bin << 1;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_CONV_END) begin
                            r_data  <= w_nextByte;
                            r_valid <= 1'b1;
                            r_state <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (iReady) begin
                            if (r_idx == c_LAST_IDX) begin
                                r_idx   <= '0;
                                r_data  <= 8'hFF;
                                r_valid <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_idx  <= w_nextIdx;
                                r_data <= w_nextByte;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_data  <= 8'hFF;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign oTX_DATA = r_data;
    assign oValid   = r_valid;
    assign oBusy    = r_busy;
    assign oMsgDone = r_done;

endmodule
`default_nettype wire

// File: doc/tx_msg_formatter.md
TX_MSG_FORMATTER -- requirements
Module: tx_msg_formatter

Interface
REQ-001 Parameter RATE_W, default 8: width of the binary rate input.
REQ-002 Parameter RATE_DIGITS, default 3, legal 1..5: number of ASCII decimal digits emitted for the rate field.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 iTX_START_CONTROL  input  1  requests messages in mode "rate control" (highest priority).
REQ-007 iTX_INITIAL  input  1  requests messages in mode "initial" (second priority).
REQ-008 iTX_NORMAL  input  1  requests messages in mode "normal" (lowest priority).
REQ-009 iRATE  input  RATE_W  unsigned binary rate value, sampled at message start.
REQ-010 iFINISH  input  1  synchronous abort; highest priority of all non-reset inputs.
REQ-011 iReady  input  1  downstream UART transmitter accepts oTX_DATA this cycle.
REQ-012 oTX_DATA  output  8  current ASCII byte.
REQ-013 oValid  output  1  oTX_DATA is valid; a byte transfers on oValid & iReady.
REQ-014 oBusy  output  1  high in CONV and SEND states.
REQ-015 oMsgDone  output  1  one-cycle pulse on acceptance of the final byte of a message.

Function
REQ-016 FSM states: IDLE, CONV, SEND; one state transition at most per clk.
REQ-017 IDLE: oValid=0, oTX_DATA=8'hFF; when any mode input is high, latch the highest-priority mode and iRATE, clear the byte index, enter CONV.
REQ-018 CONV: binary-to-BCD double-dabble over exactly RATE_W cycles, then enter SEND; no oValid during CONV.
REQ-019 Saturation: if the latched rate exceeds 10^RATE_DIGITS-1, every digit is '9' (0x39).
REQ-020 Digits: leading zeros kept, most significant digit first, each digit = 0x30 + BCD.
REQ-021 Message layout in byte index order:
- 0-13: "current state:"
- 14-25: mode label, left-justified and space-padded to 12 chars ("rate control", "initial", "normal")
- 26-27: two spaces (0x20)
- 28-32: "rate:"
- next RATE_DIGITS bytes: the rate digits
- last: the terminator (REQ-035)
REQ-022 Message length L = 33 + RATE_DIGITS + terminator length; the index counter is ceil(log2(L+1)) bits wide.
REQ-023 SEND: oValid=1; on oValid & iReady, advance the index; when not accepted, oTX_DATA and oValid hold stable.
REQ-024 On acceptance of index L-1: pulse oMsgDone and enter IDLE; if a mode input is still high, the next message starts from IDLE on the following cycle.
REQ-025 Mode and rate are frozen for the whole message; mode-input changes mid-message have no effect until the next IDLE.
REQ-026 When all mode inputs drop mid-message, the current message completes.
REQ-027 iFINISH high in any state: next state IDLE, oValid=0, oTX_DATA=8'hFF, index cleared, oMsgDone=0, latched rate kept.
REQ-028 iFINISH coincident with final-byte acceptance: the abort wins; no oMsgDone.
REQ-029 While iFINISH stays high, the block remains in IDLE.

Reset
REQ-030 On reset assertion: state=IDLE, oTX_DATA=8'hFF, oValid=0, oBusy=0, oMsgDone=0, index=0, latched mode=normal, latched rate=0.
REQ-031 Reset asserted mid-message discards the message; after release, output starts from byte 0.
REQ-032 The text ROM is constant logic, not reset-loaded storage.

Configuration
REQ-033 Macro TX_MSG_CRLF_EN selects the terminator.
REQ-034 With TX_MSG_CRLF_EN defined: terminator is 0x0D then 0x0A; L = 35 + RATE_DIGITS.
REQ-035 Without TX_MSG_CRLF_EN: terminator is 0x0A only; L = 34 + RATE_DIGITS.

Verification
REQ-036 Reset check: reset=1 -> oTX_DATA=0xFF, oValid=0, oBusy=0, oMsgDone=0; holds for 3 cycles after release with all modes low.
REQ-037 Initial mode, no macro, defaults: iTX_INITIAL=1, iRATE=49, iReady=1 -> oValid rises 9 cycles after request, 37 bytes "current state:initial       rate:049\n", oMsgDone on byte 36.
REQ-038 Backpressure: iTX_NORMAL=1, iRATE=7, iReady toggling with a random 30% duty -> exact byte sequence, no drop or duplicate, oTX_DATA stable while oValid & !iReady.
REQ-039 Saturation: RATE_DIGITS=2, iRATE=255, iTX_START_CONTROL=1 -> label "rate control", digits "99".
REQ-040 Abort: iFINISH pulsed on acceptance of byte 10 -> next cycle oValid=0, oTX_DATA=0xFF, no oMsgDone; next message restarts at 'c'.
REQ-041 Priority and macro: all three modes high, TX_MSG_CRLF_EN defined -> label "rate control", last two bytes 0x0D 0x0A, L=38.
